tzcnt96_seq: RTL and testbench
==============================

Name: tzcnt96_seq

Overview:
- Multi-cycle trailing-zero locator for the FPU rounding/normalise path.
- Given a 96-bit vector, it returns the index of the lowest set bit, or WID if no bit is set.
- It is the inverse query of the bit-range OR-reduce used for sticky generation. That block answers "is any bit at or below index a set?"; this block answers "what is the lowest index with a bit set?"
- It scans CHUNK bits per cycle so the block stays off the critical path, and it is ready/valid handshaked on both sides.

Parameters:
- WID, 96, width of the input vector; must be a multiple of CHUNK.
- CHUNK, 8, bits examined per scan cycle.
- PW, 7, result width; equals clog2(WID+1) so that the value WID is representable.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- abort_i  in  1  synchronous abort; returns the block to IDLE and drops any result.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  block can accept a request.
- dat_i  in  WID  vector to search.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- pos_o  out  PW  index of the lowest set bit, or WID when the vector is all-zero.
- zero_o  out  1  vector was all-zero.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, in_ready_o=1, out_valid_o=0, pos_o=0, zero_o=0, chunk index=0, data register=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready_o=1.
  - When in_valid_i=1, the edge captures dat_i into the data register, sets chunk index k=0 and moves to SCAN.
- SCAN:
  - in_ready_o=0, out_valid_o=0.
  - Each cycle examines register bits [k*CHUNK +: CHUNK].
  - If any bit in that slice is set: priority-encode the lowest offset f, load pos_o=k*CHUNK+f, zero_o=0, and move to DONE.
  - Else if k is the last chunk (k = WID/CHUNK-1): load pos_o=WID, zero_o=1, and move to DONE.
  - Otherwise k increments.
  - pos_o arithmetic is unsigned, PW bits wide, and cannot overflow.
- Latency:
  - Accept edge N.
  - If the lowest set bit is in chunk k, out_valid_o is 1 after edge N+1+k.
  - For an all-zero vector, out_valid_o is 1 after edge N+WID/CHUNK.
- DONE:
  - out_valid_o=1; pos_o and zero_o are held stable while out_ready_i=0.
  - When out_ready_i=1, the edge moves to IDLE and out_valid_o falls.
  - There is no same-cycle accept of a new request; in_ready_o=0 while in DONE.
- abort_i:
  - Takes priority over all transitions; the next state is IDLE and out_valid_o=0.
  - pos_o and zero_o keep their last values and are don't-care.
- in_valid_i asserted outside IDLE is ignored; the input is not captured.
- dat_i only needs to be stable on the accept edge.
- Reset asserted mid-SCAN or mid-DONE: the block returns immediately to reset values and no result is emitted.
- Elaboration check: WID % CHUNK != 0 is a fatal error.

Optional Feature:
- Macro: TZCNT96_EARLY_ZERO_EN.
- When defined:
  - On the accept edge, a full-width OR-reduce of dat_i is evaluated.
  - If it is 0, the block goes directly IDLE->DONE with pos_o=WID and zero_o=1; out_valid_o is 1 after edge N.
  - Non-zero vectors behave exactly as in the base behaviour.
- When undefined:
  - All-zero vectors take the full WID/CHUNK scan cycles.
  - No full-width OR logic is instantiated.

Test Plan:
- dat_i=96'h1, accepted at edge N -> out_valid_o=1 after N+1, pos_o=0, zero_o=0; with out_ready_i=1 the next state is IDLE and in_ready_o=1.
- dat_i = bit 95 only (CHUNK=8) -> 12 scan cycles; out_valid_o after N+12, pos_o=95, zero_o=0.
- dat_i = bits 17, 40 and 90 set -> out_valid_o after N+3, pos_o=17.
- dat_i=0:
  - Macro undefined -> pos_o=96, zero_o=1, out_valid_o after N+12.
  - Macro defined -> same pos_o and zero_o, out_valid_o after N.
- Backpressure: result pos_o=40 with out_ready_i held 0 for 5 cycles -> out_valid_o, pos_o and zero_o are unchanged.
  - in_valid_i=1 during those cycles with a different dat_i is ignored.
  - Raising out_ready_i -> IDLE the following cycle.
- Abort and reset:
  - abort_i pulsed in the 3rd SCAN cycle for dat_i = bit 80 -> IDLE next cycle and no out_valid_o.
  - A separate run with rst_ni dropped mid-SCAN, asynchronously between edges -> outputs go to reset values immediately, before the next clock.

Source files
------------

// File: rtl/tzcnt96_seq_if.sv
// Request/result handshake bundle for tzcnt96_seq.
// slave is the locator's view, master is the requester/consumer view.
interface tzcnt96_seq_if #(
  parameter int unsigned WID = 96,
  parameter int unsigned PW  = 7
);
  logic           in_valid_i;
  logic           in_ready_o;
  logic [WID-1:0] dat_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [PW-1:0]  pos_o;
  logic           zero_o;

  modport slave (
    input  in_valid_i, dat_i, out_ready_i,
    output in_ready_o, out_valid_o, pos_o, zero_o
  );

  modport master (
    output in_valid_i, dat_i, out_ready_i,
    input  in_ready_o, out_valid_o, pos_o, zero_o
  );
endinterface

// File: rtl/tzcnt96_seq.sv
// Multi-cycle trailing-zero locator: scans CHUNK bits per cycle for the lowest set bit.
// Optional TZCNT96_EARLY_ZERO_EN: all-zero vectors skip the scan and go straight to DONE.
module tzcnt96_seq #(
  parameter int unsigned WID   = 96,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned PW    = 7
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           abort_i,
  tzcnt96_seq_if.slave   bus
);
  localparam int unsigned NCH = WID / CHUNK;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned FW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  if (WID % CHUNK != 0) begin : g_bad_chunk
    $fatal(1, "tzcnt96_seq: WID must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [WID-1:0] data_q, data_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic           zero_q, zero_d;

  logic [CHUNK-1:0] slice;
  logic             found;
  logic [FW-1:0]    f;

  always_comb begin
    slice = data_q[k_q*CHUNK +: CHUNK];
    found = 1'b0;
    f     = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (!found && slice[i]) begin
        found = 1'b1;
        f     = FW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    pos_d   = pos_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          data_d  = bus.dat_i;
          k_d     = '0;
          state_d = SCAN;
`ifdef TZCNT96_EARLY_ZERO_EN
          if (~|bus.dat_i) begin
            pos_d   = PW'(WID);
            zero_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      SCAN: begin
        if (found) begin
          pos_d   = PW'(k_q) * PW'(CHUNK) + PW'(f);
          zero_d  = 1'b0;
          state_d = DONE;
        end else if (k_q == KW'(NCH - 1)) begin
          pos_d   = PW'(WID);
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort only redirects control; the captured data and last result are left as-is.
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      data_q  <= '0;
      pos_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      pos_q   <= pos_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.pos_o       = pos_q;
  assign bus.zero_o      = zero_q;
endmodule

// File: tb/tb_tzcnt96_seq.sv
// Self-checking bench for tzcnt96_seq: directed cases plus random vectors vs. an arithmetic model.
module tb_tzcnt96_seq;
  localparam int WID   = 96;
  localparam int CHUNK = 8;
  localparam int PW    = 7;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic abort_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tzcnt96_seq_if #(.WID(WID), .PW(PW)) bus ();

  tzcnt96_seq #(.WID(WID), .CHUNK(CHUNK), .PW(PW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .abort_i(abort_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Lowest set index by plain search; WID when nothing is set.
  function automatic int ref_pos(input logic [WID-1:0] v);
    for (int i = 0; i < WID; i++) if (v[i]) return i;
    return WID;
  endfunction

  function automatic int ref_lat(input logic [WID-1:0] v);
    int p;
    p = ref_pos(v);
    if (p == WID) begin
`ifdef TZCNT96_EARLY_ZERO_EN
      return 0;
`else
      return WID / CHUNK;
`endif
    end
    return p / CHUNK + 1;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request, measure latency, hold the result for `hold` cycles, then drain.
  task automatic run(input string tag, input logic [WID-1:0] v, input int hold,
                     input logic poke);
    int cyc;
    int p;
    logic [PW-1:0] p0;
    logic z0;
    p = ref_pos(v);
    check({tag, "_in_ready"}, int'(bus.in_ready_o), 1);
    bus.dat_i      = v;
    bus.in_valid_i = 1'b1;
    bus.out_ready_i = 1'b0;
    step();
    bus.in_valid_i = 1'b0;
    bus.dat_i      = '0;
    cyc = 0;
    while (!bus.out_valid_o && cyc < 40) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, ref_lat(v));
    check({tag, "_pos"}, int'(bus.pos_o), p);
    check({tag, "_zero"}, int'(bus.zero_o), (p == WID) ? 1 : 0);
    p0 = bus.pos_o;
    z0 = bus.zero_o;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        bus.in_valid_i = 1'b1;
        bus.dat_i      = 96'h1;
      end
      step();
      check({tag, "_hold_valid"}, int'(bus.out_valid_o), 1);
      check({tag, "_hold_pos"}, int'(bus.pos_o), int'(p0));
      check({tag, "_hold_zero"}, int'(bus.zero_o), int'(z0));
      check({tag, "_hold_in_ready"}, int'(bus.in_ready_o), 0);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
    check({tag, "_drain_valid"}, int'(bus.out_valid_o), 0);
    check({tag, "_drain_in_ready"}, int'(bus.in_ready_o), 1);
  endtask

  initial begin
    logic [WID-1:0] v;
    int seen;
    bus.in_valid_i  = 1'b0;
    bus.dat_i       = '0;
    bus.out_ready_i = 1'b0;

    #12;
    check("rst_in_ready", int'(bus.in_ready_o), 1);
    check("rst_out_valid", int'(bus.out_valid_o), 0);
    check("rst_pos", int'(bus.pos_o), 0);
    check("rst_zero", int'(bus.zero_o), 0);
    rst_ni = 1'b1;
    step();

    v = '0; v[0] = 1'b1;
    run("bit0", v, 0, 1'b0);
    v = '0; v[95] = 1'b1;
    run("bit95", v, 0, 1'b0);
    v = '0; v[17] = 1'b1; v[40] = 1'b1; v[90] = 1'b1;
    run("bits17_40_90", v, 0, 1'b0);
    v = '0;
    run("all_zero", v, 1, 1'b0);
    v = '0; v[40] = 1'b1; v[70] = 1'b1;
    run("backpressure", v, 5, 1'b1);
    check("bp_not_captured_valid", int'(bus.out_valid_o), 0);

    // Abort in the third scan cycle of a bit-80 search.
    v = '0; v[80] = 1'b1;
    bus.dat_i = v;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    step();
    step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort_in_ready", int'(bus.in_ready_o), 1);
    check("abort_out_valid", int'(bus.out_valid_o), 0);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.out_valid_o) seen++;
    end
    check("abort_no_result", seen, 0);

    // Asynchronous reset between edges during a scan.
    bus.dat_i = v;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_in_ready", int'(bus.in_ready_o), 1);
    check("arst_out_valid", int'(bus.out_valid_o), 0);
    check("arst_pos", int'(bus.pos_o), 0);
    check("arst_zero", int'(bus.zero_o), 0);
    step();
    rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.out_valid_o) seen++;
    end
    check("arst_no_result", seen, 0);

    for (int n = 0; n < 40; n++) begin
      v = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: v = v << $urandom_range(0, 95);
        1: v = v & {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom}
                 & ({WID{1'b1}} << $urandom_range(0, 95));
        2: if ($urandom_range(0, 3) == 0) v = '0;
        default: ;
      endcase
      run("random", v, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
